// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Address/instruction widths, PC step, cache index width, FSM states.
package ifetch_pkg;

  localparam int ADDR_BUS     = 32;
  localparam int INST_BUS     = 32;
  localparam int PC_STEP      = 4;
  localparam int ICACHE_IDX_W = 6;

  typedef enum logic [1:0] {
    FETCH_LOOKUP,
    FETCH_MISS,
    FETCH_DROP
  } fetch_state_e;

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bus: memctrl request/response, IQ output, redirect input.
// master = ifetch side, slave = memctrl / IQ / branch side.
interface ifetch_if
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_BUS
);

  logic                mc_en;
  logic [ADDR_W-1:0]   mc_addr;
  logic                mc_done;
  logic [INST_BUS-1:0] mc_inst;

  logic                iq_full;
  logic                iq_en;
  logic [INST_BUS-1:0] iq_inst;
  logic [ADDR_W-1:0]   iq_pc;

  logic                jmp_en;
  logic [ADDR_W-1:0]   jmp_pc;

  modport master (
    output mc_en, mc_addr,
    input  mc_done, mc_inst,
    input  iq_full,
    output iq_en, iq_inst, iq_pc,
    input  jmp_en, jmp_pc
  );

  modport slave (
    input  mc_en, mc_addr,
    output mc_done, mc_inst,
    output iq_full,
    input  iq_en, iq_inst, iq_pc,
    output jmp_en, jmp_pc
  );

endinterface

// File: rtl/ifetch_icache.sv
// Direct-mapped I-cache, one instruction per line, async read by pc.
// Ports: clk, rst (clears valid), rd_addr->hit/rd_data, wr_* sync write.
module ifetch_icache
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_BUS,
  parameter int IDX_W  = ICACHE_IDX_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                hit,
  output logic [INST_BUS-1:0] rd_data,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [INST_BUS-1:0] wr_data
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [INST_BUS-1:0] data_q [LINES];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;

  assign rd_idx = rd_addr[IDX_W+1:2];
  assign rd_tag = rd_addr[ADDR_W-1:IDX_W+2];
  assign wr_idx = wr_addr[IDX_W+1:2];
  assign wr_tag = wr_addr[ADDR_W-1:IDX_W+2];

  assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data = data_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: PC, I-cache lookup, miss fetch, redirects.
// Ports: clk, rst (sync, high), rdy (freeze when low), bus (ifetch_if.master).
module ifetch
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_BUS,
  parameter int IDX_W  = ICACHE_IDX_W
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  ifetch_if.master bus
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   miss_q, miss_d;
  logic                iq_en_q, iq_en_d;
  logic [INST_BUS-1:0] iq_inst_q, iq_inst_d;
  logic [ADDR_W-1:0]   iq_pc_q, iq_pc_d;
  logic                fill;
  logic                hit;
  logic [INST_BUS-1:0] line;

  ifetch_icache #(
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_icache (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (pc_q),
    .hit     (hit),
    .rd_data (line),
    .wr_en   (fill && rdy),
    .wr_addr (miss_q),
    .wr_data (bus.mc_inst)
  );

  assign bus.mc_en   = (state_q != FETCH_LOOKUP);
  assign bus.mc_addr = miss_q;
  assign bus.iq_en   = iq_en_q;
  assign bus.iq_inst = iq_inst_q;
  assign bus.iq_pc   = iq_pc_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    miss_d    = miss_q;
    iq_en_d   = 1'b0;
    iq_inst_d = iq_inst_q;
    iq_pc_d   = iq_pc_q;
    fill      = 1'b0;
    unique case (state_q)
      FETCH_LOOKUP: begin
        if (bus.jmp_en) begin
          pc_d = bus.jmp_pc;
        end else if (hit && !bus.iq_full) begin
          iq_en_d   = 1'b1;
          iq_inst_d = line;
          iq_pc_d   = pc_q;
          pc_d      = pc_q + STEP;
        end else if (!hit) begin
          miss_d  = pc_q;
          state_d = FETCH_MISS;
        end
      end
      FETCH_MISS: begin
        if (bus.mc_done) begin
          // Line address is still right even when redirected.
          fill    = 1'b1;
          state_d = FETCH_LOOKUP;
          if (bus.jmp_en) begin
            pc_d = bus.jmp_pc;
          end else if (!bus.iq_full) begin
            iq_en_d   = 1'b1;
            iq_inst_d = bus.mc_inst;
            iq_pc_d   = miss_q;
            pc_d      = pc_q + STEP;
          end
        end else if (bus.jmp_en) begin
          // memctrl cannot cancel: keep requesting, discard result.
          pc_d    = bus.jmp_pc;
          state_d = FETCH_DROP;
        end
      end
      FETCH_DROP: begin
        if (bus.jmp_en) begin
          pc_d = bus.jmp_pc;
        end
        if (bus.mc_done) begin
          fill    = 1'b1;
          state_d = FETCH_LOOKUP;
        end
      end
      default: state_d = FETCH_LOOKUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH_LOOKUP;
      pc_q      <= '0;
      miss_q    <= '0;
      iq_en_q   <= 1'b0;
      iq_inst_q <= '0;
      iq_pc_q   <= '0;
    end else if (rdy) begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      miss_q    <= miss_d;
      iq_en_q   <= iq_en_d;
      iq_inst_q <= iq_inst_d;
      iq_pc_q   <= iq_pc_d;
    end
  end

endmodule
